// File: rtl/evp_if.sv
// EVP instruction bus: start/operands from the dispatcher, N/S RAM read ports,
// and the result/status FIFO write side.
interface evp_if #(
  parameter int unsigned word_size = 16,
  parameter int unsigned n_size    = 8,
  parameter int unsigned s_size    = 88
);
  localparam int unsigned N_AW = $clog2(n_size);
  localparam int unsigned S_AW = $clog2(s_size);

  logic                        start_evp;
  logic [2:0]                  A;
  logic signed [word_size-1:0] x_in;
  logic [4:0]                  N_in;
  logic signed [word_size-1:0] s_coeff;
  logic                        en_rd_N;
  logic [N_AW-1:0]             rd_addr_N;
  logic                        en_rd_S;
  logic [S_AW-1:0]             rd_addr_S;
  logic                        done_evp;
  logic signed [31:0]          result;
  logic [31:0]                 status;
  logic                        fifo_wr_en_r;
  logic                        fifo_wr_en_s;

  modport master (
    output start_evp, A, x_in, N_in, s_coeff,
    input  en_rd_N, rd_addr_N, en_rd_S, rd_addr_S,
    input  done_evp, result, status, fifo_wr_en_r, fifo_wr_en_s
  );

  modport slave (
    input  start_evp, A, x_in, N_in, s_coeff,
    output en_rd_N, rd_addr_N, en_rd_S, rd_addr_S,
    output done_evp, result, status, fifo_wr_en_r, fifo_wr_en_s
  );
endinterface

// File: rtl/evp_fsm.sv
// EVP instruction FSM: reads degree N of polynomial A from N RAM, walks its
// coefficients in S RAM from A*11+N down to A*11 and evaluates it at x by
// Horner's rule, then writes one result and one status word to the FIFOs.
// Optional feature macro: EVP_OVF_DETECT_EN (sticky signed-32 overflow -> status 3).
module evp_fsm #(
  parameter int unsigned word_size   = 16,
  parameter int unsigned buffer_size = 1024,
  parameter int unsigned n_size      = 8,
  parameter int unsigned s_size      = 88
) (
  input logic  clk,
  input logic  rst,
  input logic  rst_instr,
  evp_if.slave bus
);
  localparam int unsigned N_AW   = $clog2(n_size);
  localparam int unsigned S_AW   = $clog2(s_size);
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned MAX_N  = 10;
  localparam int unsigned COEFFS = 11;

  // Depths below one full polynomial table cannot hold the 8 x 11 layout.
  generate
    if (buffer_size == 0 || n_size < 8 || s_size < 88) begin : g_cfg_check
      $error("evp_fsm: unsupported RAM depth configuration");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, RD_N, CHK_N, LOAD, MAC, ERROR, END} state_t;

  state_t                      state, state_nxt;
  logic [2:0]                  a_q, a_nxt;
  logic signed [word_size-1:0] x_q, x_nxt;
  logic [IDX_W-1:0]            idx, idx_nxt;
  logic signed [ACC_W-1:0]     acc, acc_nxt;
  logic signed [ACC_W-1:0]     result_q, result_nxt;
  logic [ACC_W-1:0]            status_q, status_nxt;
  logic signed [ACC_W-1:0]     coeff_ext, x_ext, prod_lo, mac_val;

`ifdef EVP_OVF_DETECT_EN
  localparam int unsigned PROD_W = ACC_W + word_size;
  localparam int unsigned SUM_W  = ACC_W + 1;
  logic                     ovf_q, ovf_nxt, step_ovf;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [SUM_W-1:0]  sum_full;
`endif

  // Coefficient address of term off of polynomial a.
  function automatic logic [S_AW-1:0] s_addr(input logic [2:0] a, input logic [IDX_W-1:0] off);
    return S_AW'(32'(a) * 32'(COEFFS) + 32'(off));
  endfunction

  // Horner step datapath, wrapped to 32 bits.
  assign coeff_ext = ACC_W'(bus.s_coeff);
  assign x_ext     = ACC_W'(x_q);
  assign prod_lo   = acc * x_ext;
  assign mac_val   = prod_lo + coeff_ext;

`ifdef EVP_OVF_DETECT_EN
  // Exact product and sum compared against their wrapped 32-bit forms.
  assign prod_full = PROD_W'(acc) * PROD_W'(x_q);
  assign sum_full  = SUM_W'(prod_lo) + SUM_W'(coeff_ext);
  assign step_ovf  = (prod_full != PROD_W'(prod_lo)) || (sum_full != SUM_W'(mac_val));
`endif

  assign bus.result = result_q;
  assign bus.status = status_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, datapath next values and RAM/FIFO strobes decoded from state.
  always_comb begin
    state_nxt        = state;
    a_nxt            = a_q;
    x_nxt            = x_q;
    idx_nxt          = idx;
    acc_nxt          = acc;
    result_nxt       = result_q;
    status_nxt       = status_q;
`ifdef EVP_OVF_DETECT_EN
    ovf_nxt          = ovf_q;
`endif
    bus.en_rd_N      = 1'b0;
    bus.rd_addr_N    = '0;
    bus.en_rd_S      = 1'b0;
    bus.rd_addr_S    = '0;
    bus.done_evp     = 1'b0;
    bus.fifo_wr_en_r = 1'b0;
    bus.fifo_wr_en_s = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start_evp) begin
          a_nxt     = bus.A;
          x_nxt     = bus.x_in;
`ifdef EVP_OVF_DETECT_EN
          ovf_nxt   = 1'b0;
`endif
          state_nxt = RD_N;
        end
      end
      RD_N: begin
        bus.en_rd_N   = 1'b1;
        bus.rd_addr_N = N_AW'(a_q);
        state_nxt     = CHK_N;
      end
      CHK_N: begin
        if (bus.N_in > 5'(MAX_N)) begin
          state_nxt = ERROR;
        end else begin
          idx_nxt       = IDX_W'(bus.N_in);
          bus.en_rd_S   = 1'b1;
          bus.rd_addr_S = s_addr(a_q, IDX_W'(bus.N_in));
          state_nxt     = LOAD;
        end
      end
      LOAD, MAC: begin
        if (state == LOAD) begin
          acc_nxt = coeff_ext;
        end else begin
          acc_nxt = mac_val;
`ifdef EVP_OVF_DETECT_EN
          ovf_nxt = ovf_q | step_ovf;
`endif
        end
        if (idx == '0) begin
          result_nxt = acc_nxt;
          status_nxt = '0;
`ifdef EVP_OVF_DETECT_EN
          if (ovf_nxt) status_nxt = ACC_W'(3);
`endif
          state_nxt  = END;
        end else begin
          bus.en_rd_S   = 1'b1;
          bus.rd_addr_S = s_addr(a_q, idx - IDX_W'(1));
          idx_nxt       = idx - IDX_W'(1);
          state_nxt     = MAC;
        end
      end
      ERROR: begin
        result_nxt = '0;
        status_nxt = ACC_W'(2);
        state_nxt  = END;
      end
      END: begin
        bus.done_evp     = 1'b1;
        bus.fifo_wr_en_r = 1'b1;
        bus.fifo_wr_en_s = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Instruction abort returns everything to the reset picture.
    if (!rst_instr) begin
      state_nxt  = IDLE;
      result_nxt = '0;
      status_nxt = '1;
    end
  end

  // Datapath and result/status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      x_q      <= '0;
      idx      <= '0;
      acc      <= '0;
      result_q <= '0;
      status_q <= '1;
`ifdef EVP_OVF_DETECT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_q      <= a_nxt;
      x_q      <= x_nxt;
      idx      <= idx_nxt;
      acc      <= acc_nxt;
      result_q <= result_nxt;
      status_q <= status_nxt;
`ifdef EVP_OVF_DETECT_EN
      ovf_q    <= ovf_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_evp_fsm.sv
// Bench for evp_fsm: RAM models, directed polynomial cases, abort, and random
// polynomials checked against a power-sum reference evaluation.
module tb_evp_fsm;
  logic clk;
  logic rst;
  logic rst_instr;

  evp_if bus ();

  evp_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .rst_instr (rst_instr),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  n_ram [8];
  logic [15:0] s_ram [128];
  logic [6:0]  addr_q [$];
  int total = 0;
  int bad   = 0;

  // Synchronous-read RAMs: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (bus.en_rd_N) bus.N_in <= n_ram[bus.rd_addr_N];
    if (bus.en_rd_S) bus.s_coeff <= s_ram[bus.rd_addr_S];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value = sum c_i * x^i taken mod 2^32 (equal to wrapped Horner).
  function automatic void model(input int a, input logic signed [15:0] x,
                                output logic [31:0] r, output logic [31:0] st, output int cyc);
    int n;
    longint sum, p;
`ifdef EVP_OVF_DETECT_EN
    longint acc, pr, sm;
    bit ovf;
`endif
    n = int'(n_ram[a]);
    if (n > 10) begin
      r = 32'd0; st = 32'd2; cyc = 4;
      return;
    end
    sum = 0;
    p   = 1;
    for (int i = 0; i <= n; i++) begin
      sum += longint'($signed(s_ram[a*11+i])) * p;
      p = p * longint'(x);
    end
    r   = sum[31:0];
    st  = 32'd0;
    cyc = n + 4;
`ifdef EVP_OVF_DETECT_EN
    ovf = 1'b0;
    acc = longint'($signed(s_ram[a*11+n]));
    for (int i = n - 1; i >= 0; i--) begin
      pr = acc * longint'(x);
      if (pr > 64'sd2147483647 || pr < -64'sd2147483648) ovf = 1'b1;
      pr = longint'($signed(pr[31:0]));
      sm = pr + longint'($signed(s_ram[a*11+i]));
      if (sm > 64'sd2147483647 || sm < -64'sd2147483648) ovf = 1'b1;
      acc = longint'($signed(sm[31:0]));
    end
    if (ovf) st = 32'd3;
`endif
  endfunction

  // One instruction: start pulse, then watch strobes until the FIFO write.
  task automatic run_evp(input logic [2:0] a, input logic signed [15:0] x, input bit poke,
                         output logic [31:0] res, output logic [31:0] st,
                         output int pc, output bit s_seen);
    addr_q.delete();
    s_seen = 1'b0;
    pc     = -1;
    res    = 'x;
    st     = 'x;
    @(negedge clk);
    bus.start_evp = 1'b1;
    bus.A         = a;
    bus.x_in      = x;
    @(negedge clk);
    bus.start_evp = 1'b0;
    bus.A         = 3'($urandom);
    bus.x_in      = 16'($urandom);
    for (int k = 1; k <= 40; k++) begin
      bus.start_evp = poke && (k == 2);
      if (bus.en_rd_S) begin
        s_seen = 1'b1;
        addr_q.push_back(bus.rd_addr_S);
      end
      if (bus.fifo_wr_en_r) begin
        pc  = k;
        res = bus.result;
        st  = bus.status;
        break;
      end
      @(negedge clk);
    end
    bus.start_evp = 1'b0;
    if (pc > 0) begin
      chk("pulse_done", 32'(bus.done_evp), 32'd1);
      chk("pulse_fifo_s", 32'(bus.fifo_wr_en_s), 32'd1);
      @(negedge clk);
      chk("pulse_one_cycle", 32'({bus.done_evp, bus.fifo_wr_en_r, bus.fifo_wr_en_s}), 32'd0);
    end
  endtask

  // Run one case and compare against the reference model.
  task automatic check_case(input string tag, input logic [2:0] a, input logic signed [15:0] x,
                            input bit poke, output logic [31:0] r, output logic [31:0] st,
                            output int pc);
    logic [31:0] er, est;
    int ec, n, addr_err;
    bit s_seen;
    model(int'(a), x, er, est, ec);
    run_evp(a, x, poke, r, st, pc, s_seen);
    chk({tag, "_result"}, r, er);
    chk({tag, "_status"}, st, est);
    chk({tag, "_cycle"}, 32'(pc), 32'(ec));
    n = int'(n_ram[a]);
    if (n > 10) begin
      chk({tag, "_no_s_read"}, 32'(s_seen), 32'd0);
    end else begin
      addr_err = (addr_q.size() != n + 1) ? 1 : 0;
      foreach (addr_q[i])
        if (int'(addr_q[i]) != int'(a) * 11 + n - i) addr_err++;
      chk({tag, "_addrs"}, 32'(addr_err), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r, st;
    int pc, pulses, nn;
    logic [2:0] ra;
    logic signed [15:0] rx;

    rst           = 1'b1;
    rst_instr     = 1'b1;
    bus.start_evp = 1'b0;
    bus.A         = '0;
    bus.x_in      = '0;
    foreach (n_ram[i]) n_ram[i] = 5'h1F;
    foreach (s_ram[i]) s_ram[i] = 16'($urandom);

    // Reset picture.
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_status", bus.status, 32'hFFFFFFFF);
    chk("rst_en_rd_N", 32'(bus.en_rd_N), 32'd0);
    chk("rst_en_rd_S", 32'(bus.en_rd_S), 32'd0);
    chk("rst_addrs", 32'({bus.rd_addr_N, bus.rd_addr_S}), 32'd0);
    chk("rst_pulses", 32'({bus.done_evp, bus.fifo_wr_en_r, bus.fifo_wr_en_s}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // T1: 1*x^2 - 2*x + 3 at x=5, with an ignored start pulse mid-run.
    s_ram[22] = 16'd3;
    s_ram[23] = 16'hFFFE;
    s_ram[24] = 16'd1;
    n_ram[2]  = 5'd2;
    check_case("T1", 3'd2, 16'sd5, 1'b1, r, st, pc);
    chk("T1_spec_result", r, 32'd18);
    chk("T1_spec_status", st, 32'd0);
    chk("T1_spec_cycle", 32'(pc), 32'd6);

    // T2: degree 0.
    n_ram[0] = 5'd0;
    s_ram[0] = 16'hFFF9;
    check_case("T2", 3'd0, 16'sd100, 1'b0, r, st, pc);
    chk("T2_spec_result", r, 32'hFFFFFFF9);
    chk("T2_spec_cycle", 32'(pc), 32'd4);

    // T3: N out of range.
    n_ram[3] = 5'd11;
    check_case("T3", 3'd3, 16'sd7, 1'b0, r, st, pc);
    chk("T3_spec_status", st, 32'd2);
    chk("T3_spec_result", r, 32'd0);

    // T4: top slot, full degree, x=-1.
    n_ram[7] = 5'd10;
    for (int i = 0; i < 11; i++) s_ram[77+i] = 16'(i + 1);
    check_case("T4", 3'd7, -16'sd1, 1'b0, r, st, pc);
    chk("T4_spec_result", r, 32'd6);
    chk("T4_first_addr", 32'(addr_q[0]), 32'd87);
    chk("T4_last_addr", 32'(addr_q[addr_q.size()-1]), 32'd77);

    // T5: abort during MAC of T1, then a clean rerun.
    @(negedge clk);
    bus.start_evp = 1'b1;
    bus.A         = 3'd2;
    bus.x_in      = 16'sd5;
    @(negedge clk);
    bus.start_evp = 1'b0;
    repeat (3) @(negedge clk);
    rst_instr = 1'b0;
    @(negedge clk);
    rst_instr = 1'b1;
    chk("T5_abort_result", bus.result, 32'd0);
    chk("T5_abort_status", bus.status, 32'hFFFFFFFF);
    chk("T5_abort_en_rd_S", 32'(bus.en_rd_S), 32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.fifo_wr_en_r || bus.done_evp) pulses++;
      @(negedge clk);
    end
    chk("T5_no_fifo_write", 32'(pulses), 32'd0);
    check_case("T5_rerun", 3'd2, 16'sd5, 1'b0, r, st, pc);
    chk("T5_rerun_spec", r, 32'd18);

    // T6: maximal coefficients and x.
    for (int i = 0; i < 11; i++) s_ram[77+i] = 16'h7FFF;
    check_case("T6", 3'd7, 16'sh7FFF, 1'b0, r, st, pc);
`ifdef EVP_OVF_DETECT_EN
    chk("T6_spec_status", st, 32'd3);
`else
    chk("T6_spec_status", st, 32'd0);
`endif

    // Random polynomials, degrees, slots and evaluation points.
    for (int t = 0; t < 24; t++) begin
      ra = 3'($urandom_range(0, 7));
      nn = $urandom_range(0, 13);
      n_ram[ra] = (nn == 13) ? 5'h1F : 5'(nn);
      for (int i = 0; i < 11; i++)
        s_ram[int'(ra)*11+i] = (t % 2 == 0) ? 16'($urandom_range(0, 20) - 10) : 16'($urandom);
      rx = (t % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 6) - 3);
      check_case($sformatf("R%0d", t), ra, rx, t % 5 == 0, r, st, pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
